div_issue_ctrl: RTL and testbench

- Upstream issue/collect stage for the team's sequential restoring divider (Start/Done protocol, one division in flight).
- Accepts operand pairs on a valid/ready stream and runs the Start/Done handshake to launch each division.
- Captures quotient and remainder, and presents results on an output valid/ready stream.
- Handles divide-by-zero locally without launching the divider, and flags a hung divider with a watchdog.

---
 rtl/div_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue/collect controller for the sequential restoring divider: operand stream in, Start/Done launch, result stream out.
// Optional build macro DIV_SIGNED_EN enables two's-complement operands (sign handled here, magnitudes sent to the divider).
module div_issue_ctrl #(
  parameter int tamanyo = 32,
  parameter int MAX_CYC = 2*tamanyo+8
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [tamanyo-1:0] in_num,
  input  logic [tamanyo-1:0] in_den,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [tamanyo-1:0] out_coc,
  output logic [tamanyo-1:0] out_res,
  output logic               out_dz,
  output logic               out_err,
  output logic               busy,
  output logic               div_start,
  output logic [tamanyo-1:0] div_num,
  output logic [tamanyo-1:0] div_den,
  input  logic [tamanyo-1:0] div_coc,
  input  logic [tamanyo-1:0] div_res,
  input  logic               div_done
);

  // state   | meaning
  // IDLE    | ready for an operand pair
  // WAIT    | divider running, Start held, watchdog counting
  // RELEASE | one cycle of Start low so the divider returns to idle
  // OUT     | result presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, WAIT, RELEASE, OUT} state_t;

  localparam int WD_W = $clog2(MAX_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYC - 1);

  state_t            state;
  logic [WD_W-1:0]   wdog;
  logic [tamanyo-1:0] num_mag;
  logic [tamanyo-1:0] den_mag;
  logic [tamanyo-1:0] cap_coc;
  logic [tamanyo-1:0] cap_res;
  logic [tamanyo-1:0] dz_coc;

`ifdef DIV_SIGNED_EN
  logic sign_q;
  logic sign_r;

  // The most negative value negates to itself, which reads as 2^(tamanyo-1) unsigned.
  always_comb begin
    num_mag = in_num[tamanyo-1] ? -in_num : in_num;
    den_mag = in_den[tamanyo-1] ? -in_den : in_den;
    cap_coc = sign_q ? -div_coc : div_coc;
    cap_res = sign_r ? -div_res : div_res;
    dz_coc  = in_num[tamanyo-1] ? tamanyo'(1) : {tamanyo{1'b1}};
  end

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign_q <= in_num[tamanyo-1] ^ in_den[tamanyo-1];
      sign_r <= in_num[tamanyo-1];
    end
  end
`else
  always_comb begin
    num_mag = in_num;
    den_mag = in_den;
    cap_coc = div_coc;
    cap_res = div_res;
    dz_coc  = {tamanyo{1'b1}};
  end
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      state     <= IDLE;
      div_start <= 1'b0;
      out_valid <= 1'b0;
      out_dz    <= 1'b0;
      out_err   <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      out_coc   <= '0;
      out_res   <= '0;
      wdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_den == '0) begin
              out_coc   <= dz_coc;
              out_res   <= in_num;
              out_dz    <= 1'b1;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              div_num   <= num_mag;
              div_den   <= den_mag;
              div_start <= 1'b1;
              wdog      <= '0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // div_done takes priority over a watchdog expiry in the same cycle
          if (div_done) begin
            out_coc   <= cap_coc;
            out_res   <= cap_res;
            out_dz    <= 1'b0;
            out_err   <= 1'b0;
            div_start <= 1'b0;
            state     <= RELEASE;
          end else if (wdog == WD_LAST) begin
            out_coc   <= '0;
            out_res   <= '0;
            out_dz    <= 1'b0;
            out_err   <= 1'b1;
            div_start <= 1'b0;
            state     <= RELEASE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RELEASE: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: table vectors, hand-written corner sequences and random traffic against a behavioural divider.
// Build with DIV_SIGNED_EN defined to also cover the signed operand cases.
module tb_div_issue_ctrl;
  localparam int W  = 32;
  localparam int MC = 2*W+8;

  logic         CLK, RSTa;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_num, in_den, out_coc, out_res;
  logic         out_dz, out_err, busy, div_start, div_done;
  logic [W-1:0] div_num, div_den, div_coc, div_res;

  div_issue_ctrl #(.tamanyo(W), .MAX_CYC(MC)) dut (
    .CLK(CLK), .RSTa(RSTa),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
    .out_valid(out_valid), .out_ready(out_ready), .out_coc(out_coc), .out_res(out_res),
    .out_dz(out_dz), .out_err(out_err), .busy(busy),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_coc(div_coc), .div_res(div_res), .div_done(div_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Behavioural divider: Start held high, Done pulses lat cycles later, Start low returns it to idle.
  int           lat  = 66;
  bit           hang = 1'b0;
  logic         stray = 1'b0;
  logic         mdone;
  int           ms, cnt;
  logic [W-1:0] mnum, mden;

  assign div_done = mdone | stray;
  assign div_coc  = (mden == '0) ? {W{1'b1}} : mnum / mden;
  assign div_res  = (mden == '0) ? mnum : mnum % mden;

  always @(posedge CLK) begin
    if (RSTa) begin
      ms    <= 0;
      mdone <= 1'b0;
      mnum  <= '0;
      mden  <= '0;
    end else begin
      case (ms)
        0: begin
          mdone <= 1'b0;
          if (div_start) begin
            cnt  <= lat;
            ms   <= 1;
            mnum <= div_num;
            mden <= div_den;
          end
        end
        1: begin
          if (!div_start) ms <= 0;
          else if (!hang) begin
            if (cnt <= 1) begin
              mdone <= 1'b1;
              ms    <= 2;
            end else cnt <= cnt - 1;
          end
        end
        default: begin
          mdone <= 1'b0;
          if (!div_start) ms <= 0;
        end
      endcase
    end
  end

  // Launch counter and shortest low gap of div_start between launches
  int   ncyc = 0, starts = 0, fall_at = -1, gap_min = 1000000;
  logic ds_q = 1'b0;
  always @(negedge CLK) begin
    ncyc++;
    if (div_start && !ds_q) begin
      starts++;
      if (fall_at >= 0 && ncyc - fall_at < gap_min) gap_min = ncyc - fall_at;
    end
    if (!div_start && ds_q) fall_at = ncyc;
    ds_q = div_start;
  end

  function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
`ifdef DIV_SIGNED_EN
    longint sn, sd;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    if (d == '0) begin
      dz = 1'b1;
      q  = (sn < 0) ? W'(1) : {W{1'b1}};
      r  = n;
    end else begin
      dz = 1'b0;
      q  = W'(sn / sd);
      r  = W'(sn % sd);
    end
`else
    if (d == '0) begin
      dz = 1'b1;
      q  = {W{1'b1}};
      r  = n;
    end else begin
      dz = 1'b0;
      q  = n / d;
      r  = n % d;
    end
`endif
  endfunction

  task automatic send(input logic [W-1:0] n, input logic [W-1:0] d, input bit hold);
    int k;
    in_num = n;
    in_den = d;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 1000) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!in_ready) timeout("send_ready");
    @(posedge CLK); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic get(input string nm, input logic [W-1:0] ec, input logic [W-1:0] er,
                     input logic edz, input logic eerr, input int stall);
    int k;
    logic stable;
    logic [W-1:0] sc, sr;
    logic sdz, serr;
    k = 0;
    while (!out_valid && k < 1000) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!out_valid) begin
      timeout({nm, "_valid"});
      return;
    end
    sc = out_coc; sr = out_res; sdz = out_dz; serr = out_err;
    stable = 1'b1;
    repeat (stall) begin
      @(posedge CLK); #1;
      if (out_valid !== 1'b1 || out_coc !== sc || out_res !== sr || out_dz !== sdz || out_err !== serr)
        stable = 1'b0;
    end
    if (stall > 0) chk({nm, "_stable"}, W'(stable), 1);
    chk({nm, "_coc"}, out_coc, ec);
    chk({nm, "_res"}, out_res, er);
    chk({nm, "_dz"}, W'(out_dz), W'(edz));
    chk({nm, "_err"}, W'(out_err), W'(eerr));
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, W'(out_valid), 0);
  endtask

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    int           lat;
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
    logic         err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, s0;
    logic [W-1:0] q, r;
    logic dz;

    tbl[0] = '{32'd100, 32'd7, 66, 32'd14, 32'd2, 1'b0, 1'b0};
    tbl[1] = '{32'd3, 32'd10, 2, 32'd0, 32'd3, 1'b0, 1'b0};
    tbl[2] = '{32'd0, 32'd5, 1, 32'd0, 32'd0, 1'b0, 1'b0};
    tbl[3] = '{32'd7, 32'd7, 3, 32'd1, 32'd0, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 32'd1, 5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'd1, 32'd0, 1'b0, 1'b0};
    tbl[6] = '{32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0};
    tbl[7] = '{32'd20, 32'd3, MC-2, 32'd6, 32'd2, 1'b0, 1'b0};
    tbl[8] = '{32'd20, 32'd3, MC-1, 32'd0, 32'd0, 1'b0, 1'b1};
    tbl[9] = '{32'd1000000, 32'd999, 4, 32'd1001, 32'd1, 1'b0, 1'b0};

    RSTa = 1'b1; in_valid = 1'b0; in_num = '0; in_den = '0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_busy", W'(busy), 0);
    chk("rst_div_start", W'(div_start), 0);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_out_coc", out_coc, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_div_num", div_num, 0);
    chk("rst_flags", W'({out_dz, out_err}), 0);
    RSTa = 1'b0;
    @(posedge CLK); #1;

    // Normal division latency: Start on the edge after transfer, out_valid two cycles after div_done
    lat = 66;
    send(32'd100, 32'd7, 1'b0);
    chk("lat_start", W'(div_start), 1);
    chk("lat_div_num", div_num, 100);
    chk("lat_div_den", div_den, 7);
    k = 0;
    while (!div_done && k < 200) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!div_done) timeout("lat_done");
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("lat_done_to_valid", k, 2);
    get("d100_7", 32'd14, 32'd2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      lat = tbl[i].lat;
      s0 = starts;
      send(tbl[i].num, tbl[i].den, 1'b0);
      get($sformatf("tbl%0d", i), tbl[i].coc, tbl[i].res, tbl[i].dz, tbl[i].err, i % 3);
      chk($sformatf("tbl%0d_launches", i), starts - s0, (tbl[i].den == '0) ? 0 : 1);
    end

    // Divide-by-zero answers one cycle after transfer without launching
    s0 = starts;
    send(32'h1234, 32'd0, 1'b0);
    chk("dz_latency", W'(out_valid), 1);
    get("dz", 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 0);
    chk("dz_no_start", starts - s0, 0);

    // Reset in the middle of WAIT
    lat = 66;
    send(32'd100, 32'd7, 1'b0);
    repeat (5) begin
      @(posedge CLK); #1;
    end
    RSTa = 1'b1;
    @(posedge CLK); #1;
    chk("rstw_busy", W'(busy), 0);
    chk("rstw_div_start", W'(div_start), 0);
    chk("rstw_in_ready", W'(in_ready), 1);
    chk("rstw_out_valid", W'(out_valid), 0);
    RSTa = 1'b0;
    lat = 3;
    send(32'd9, 32'd4, 1'b0);
    get("post_rst", 32'd2, 32'd1, 1'b0, 1'b0, 0);

    // Watchdog: divider never answers
    hang = 1'b1;
    send(32'd5, 32'd1, 1'b0);
    k = 0;
    while (!out_err && k < 200) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("wd_cycles", k, MC);
    chk("wd_release_start", W'(div_start), 0);
    chk("wd_release_valid", W'(out_valid), 0);
    get("wd", 32'd0, 32'd0, 1'b0, 1'b1, 0);
    hang = 1'b0;

    // Backpressure with back-to-back requests
    lat = 4;
    gap_min = 1000000;
    fork
      begin
        send(32'd50, 32'd5, 1'b1);
        send(32'd9, 32'd4, 1'b1);
        in_valid = 1'b0;
      end
      begin
        get("bp1", 32'd10, 32'd0, 1'b0, 1'b0, 10);
        get("bp2", 32'd2, 32'd1, 1'b0, 1'b0, 10);
      end
    join
    chk("bp_start_gap", W'(gap_min >= 2), 1);

    // A div_done pulse while idle must be ignored
    stray = 1'b1;
    @(posedge CLK); #1;
    stray = 1'b0;
    @(posedge CLK); #1;
    chk("stray_busy", W'(busy), 0);
    chk("stray_valid", W'(out_valid), 0);

`ifdef DIV_SIGNED_EN
    lat = 5;
    send(-32'sd7, 32'd2, 1'b0);
    get("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    send(32'd7, -32'sd2, 1'b0);
    get("s_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 0);
    send(-32'sd5, 32'd0, 1'b0);
    get("s_dz_neg", 32'd1, 32'hFFFF_FFFB, 1'b1, 1'b0, 0);
    send(32'h8000_0000, 32'd1, 1'b0);
    get("s_min_1", 32'h8000_0000, 32'd0, 1'b0, 1'b0, 0);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] n, d;
      n = $urandom;
      if ($urandom_range(0, 7) == 0) d = '0;
      else if ($urandom_range(0, 1) == 1) d = $urandom;
      else d = $urandom_range(1, 300);
      lat = $urandom_range(1, 20);
      ref_div(n, d, q, r, dz);
      send(n, d, 1'b0);
      get($sformatf("rnd%0d", i), q, r, dz, 1'b0, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
